// File: rtl/attempt_gate_pkg.sv
// Shared types and defaults for the attempt gate.
// Holds the FSM state encoding, default key width and lockout length.
// Also provides the timer width helper used by the lockout timer.
package attempt_gate_pkg;

  localparam int DEF_W           = 8;
  localparam int DEF_LOCK_CYCLES = 64;
  localparam int LOCK_CNT_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHECK   = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // Bits needed to hold LOCK_CYCLES-1 (never less than one bit).
  function automatic int timer_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/attempt_gate_if.sv
// Attempt/result handshake bundle between an attempt source and the gate.
// Latency: n/a (wires only). Backpressure: att_ready low stalls the source.
// Ports: att_valid/att_data/att_ready (attempt), res_valid/res_ok (result).
interface attempt_gate_if import attempt_gate_pkg::*; #(
  parameter int W = DEF_W
);
  logic         att_valid;
  logic [W-1:0] att_data;
  logic         att_ready;
  logic         res_valid;
  logic         res_ok;

  // Attempt source side.
  modport master (
    output att_valid, att_data,
    input  att_ready, res_valid, res_ok
  );

  // Gate side.
  modport slave (
    input  att_valid, att_data,
    output att_ready, res_valid, res_ok
  );
endinterface

// File: rtl/attempt_gate_lock_timer.sv
// Lockout timer: after i_start, counts LOCK_CYCLES cycles and flags the last one.
// Latency: o_done high in the LOCK_CYCLES-th cycle after the i_start edge.
// Backpressure: none; a new i_start restarts the count.
// Ports: clk, rst (sync, active-high), i_start, o_done.
module attempt_gate_lock_timer import attempt_gate_pkg::*; #(
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  output logic o_done
);
  localparam int TW = timer_w(LOCK_CYCLES);

  logic [TW-1:0] r_cnt;
  logic          r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_cnt  <= TW'(LOCK_CYCLES - 1);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt == '0) r_busy <= 1'b0;
      else             r_cnt  <= r_cnt - TW'(1);
    end
  end

  // Busy cycles see r_cnt = LOCK_CYCLES-1 .. 0, so done lands on the last one.
  assign o_done = r_busy && (r_cnt == '0);

endmodule

// File: rtl/attempt_gate.sv
// Key-compare gate with lockout: checks attempts against a loaded key.
// Latency: result strobe one cycle after acceptance; max one attempt per 2 cycles.
// Backpressure: att_ready low outside IDLE and whenever block is high.
// Ports: clk, rst (sync, active-high), att (slave handshake), i_key_load/i_key_in,
//        o_match (to failure monitor), i_block (from monitor), o_locked, o_lock_count.
module attempt_gate import attempt_gate_pkg::*; #(
  parameter int W           = DEF_W,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  attempt_gate_if.slave         att,
  input  logic                  i_key_load,
  input  logic [W-1:0]          i_key_in,
  output logic                  o_match,
  input  logic                  i_block,
  output logic                  o_locked,
  output logic [LOCK_CNT_W-1:0] o_lock_count
);
  state_t                r_state;
  logic [W-1:0]          r_key;
  logic                  r_res_valid;
  logic                  r_res_ok;
  logic                  r_match;
  logic                  r_locked;
  logic [LOCK_CNT_W-1:0] r_lock_count;

  logic                  w_idle;
  logic                  w_lock_start;
  logic                  w_timer_done;
  logic [W-1:0]          w_key_next;

  assign w_idle       = (r_state == ST_IDLE);
  assign w_lock_start = w_idle && i_block;
  // A key loaded on the acceptance cycle is the one the attempt is judged by.
  assign w_key_next   = i_key_load ? i_key_in : r_key;

  assign att.att_ready = w_idle && !i_block;

  attempt_gate_lock_timer #(.LOCK_CYCLES(LOCK_CYCLES)) u_lock_timer (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_lock_start),
    .o_done  (w_timer_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_key        <= '0;
      r_res_valid  <= 1'b0;
      r_res_ok     <= 1'b0;
      r_match      <= 1'b1;
      r_locked     <= 1'b0;
      r_lock_count <= '0;
    end else begin
      r_key       <= w_key_next;
      r_res_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_block) begin
            r_state  <= ST_LOCKED;
            r_locked <= 1'b1;
            if (r_lock_count != '1) r_lock_count <= r_lock_count + LOCK_CNT_W'(1);
          end else if (att.att_valid) begin
            // Compare is resolved on capture so a key load during CHECK
            // cannot disturb the result being presented.
            r_state     <= ST_CHECK;
            r_res_valid <= 1'b1;
            r_res_ok    <= (att.att_data == w_key_next);
          end
        end
        ST_CHECK: begin
          r_match <= r_res_ok;
          r_state <= ST_IDLE;
        end
        ST_LOCKED: begin
          if (w_timer_done) begin
            r_state  <= ST_RELEASE;
            r_locked <= 1'b0;
            r_match  <= 1'b1;
          end
        end
        ST_RELEASE: r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  assign att.res_valid = r_res_valid;
  assign att.res_ok    = r_res_ok;
  assign o_match       = r_match;
  assign o_locked      = r_locked;
  assign o_lock_count  = r_lock_count;

endmodule

// File: tb/tb_attempt_gate.sv
module tb_attempt_gate;
  localparam int W  = 8;
  localparam int LC = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_load;
  logic [W-1:0] key_in;
  logic         block;
  logic         match;
  logic         locked;
  logic [7:0]   lock_count;

  int n_tests = 0;
  int n_fail  = 0;

  attempt_gate_if #(.W(W)) att_if();

  attempt_gate #(.W(W), .LOCK_CYCLES(LC)) dut (
    .clk          (clk),
    .rst          (rst),
    .att          (att_if),
    .i_key_load   (key_load),
    .i_key_in     (key_in),
    .o_match      (match),
    .i_block      (block),
    .o_locked     (locked),
    .o_lock_count (lock_count)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic kl, input logic [W-1:0] ki,
                       input logic av, input logic [W-1:0] ad, input logic blk);
    rst = r; key_load = kl; key_in = ki;
    att_if.att_valid = av; att_if.att_data = ad; block = blk;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  // Returns at the falling edge after the next rising edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    tick(); tick();
    idle();
    n_tests++; if (att_if.res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid got %b want 0", att_if.res_valid); end
    n_tests++; if (att_if.res_ok !== 1'b0) begin n_fail++; $display("FAIL rst_res_ok got %b want 0", att_if.res_ok); end
    n_tests++; if (match !== 1'b1) begin n_fail++; $display("FAIL rst_match got %b want 1", match); end
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked got %b want 0", locked); end
    n_tests++; if (lock_count !== 8'd0) begin n_fail++; $display("FAIL rst_lock_count got %0d want 0", lock_count); end
    #1;
    n_tests++; if (att_if.att_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", att_if.att_ready); end
    // Key resets to zero, so an all-zero attempt must pass.
    drive(1'b0, 1'b0, '0, 1'b1, 8'h00, 1'b0);
    tick();
    n_tests++; if (att_if.res_valid !== 1'b1 || att_if.res_ok !== 1'b1) begin n_fail++; $display("FAIL rst_key_zero got v=%b ok=%b want 1/1", att_if.res_valid, att_if.res_ok); end
    idle(); tick();
  endtask

  task automatic test_match();
    drive(1'b0, 1'b1, 8'h5A, 1'b0, '0, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b1, 8'h5A, 1'b0);
    #1;
    n_tests++; if (att_if.att_ready !== 1'b1) begin n_fail++; $display("FAIL match_ready_idle got %b want 1", att_if.att_ready); end
    tick();
    n_tests++; if (att_if.res_valid !== 1'b1) begin n_fail++; $display("FAIL match_res_valid got %b want 1", att_if.res_valid); end
    n_tests++; if (att_if.res_ok !== 1'b1) begin n_fail++; $display("FAIL match_res_ok got %b want 1", att_if.res_ok); end
    n_tests++; if (match !== 1'b1) begin n_fail++; $display("FAIL match_level got %b want 1", match); end
    idle(); #1;
    n_tests++; if (att_if.att_ready !== 1'b0) begin n_fail++; $display("FAIL match_ready_check got %b want 0", att_if.att_ready); end
    tick();
    n_tests++; if (att_if.res_valid !== 1'b0) begin n_fail++; $display("FAIL match_strobe_end got %b want 0", att_if.res_valid); end
    n_tests++; if (att_if.res_ok !== 1'b1) begin n_fail++; $display("FAIL match_ok_held got %b want 1", att_if.res_ok); end
    n_tests++; if (match !== 1'b1) begin n_fail++; $display("FAIL match_after got %b want 1", match); end
  endtask

  task automatic test_mismatch();
    drive(1'b0, 1'b0, '0, 1'b1, 8'h11, 1'b0);
    tick();
    n_tests++; if (att_if.res_valid !== 1'b1 || att_if.res_ok !== 1'b0) begin n_fail++; $display("FAIL mis_result got v=%b ok=%b want 1/0", att_if.res_valid, att_if.res_ok); end
    n_tests++; if (match !== 1'b1) begin n_fail++; $display("FAIL mis_match_in_check got %b want 1", match); end
    idle(); tick();
    n_tests++; if (match !== 1'b0) begin n_fail++; $display("FAIL mis_match_next got %b want 0", match); end
    repeat (3) tick();
    n_tests++; if (match !== 1'b0) begin n_fail++; $display("FAIL mis_match_hold got %b want 0", match); end
    drive(1'b0, 1'b0, '0, 1'b1, 8'h5A, 1'b0);
    tick();
    n_tests++; if (att_if.res_ok !== 1'b1 || match !== 1'b0) begin n_fail++; $display("FAIL mis_recover_check got ok=%b m=%b want 1/0", att_if.res_ok, match); end
    idle(); tick();
    n_tests++; if (match !== 1'b1) begin n_fail++; $display("FAIL mis_recover got %b want 1", match); end
  endtask

  task automatic test_lockout();
    drive(1'b0, 1'b0, '0, 1'b1, 8'h22, 1'b0);
    tick(); idle(); tick();
    n_tests++; if (match !== 1'b0) begin n_fail++; $display("FAIL lock_pre_fail got %b want 0", match); end
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    #1;
    n_tests++; if (att_if.att_ready !== 1'b0) begin n_fail++; $display("FAIL lock_ready_same got %b want 0", att_if.att_ready); end
    tick();
    for (int i = 0; i < LC; i++) begin
      n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_locked_c%0d got %b want 1", i, locked); end
      // block and attempts offered during lockout must be ignored
      drive(1'b0, 1'b0, '0, 1'b1, 8'h5A, 1'b1);
      #1;
      n_tests++; if (att_if.att_ready !== 1'b0) begin n_fail++; $display("FAIL lock_ready_c%0d got %b want 0", i, att_if.att_ready); end
      tick();
    end
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_release_locked got %b want 0", locked); end
    n_tests++; if (match !== 1'b1) begin n_fail++; $display("FAIL lock_release_match got %b want 1", match); end
    n_tests++; if (att_if.res_valid !== 1'b0) begin n_fail++; $display("FAIL lock_no_strobe got %b want 0", att_if.res_valid); end
    n_tests++; if (lock_count !== 8'd1) begin n_fail++; $display("FAIL lock_count got %0d want 1", lock_count); end
    #1;
    n_tests++; if (att_if.att_ready !== 1'b0) begin n_fail++; $display("FAIL lock_ready_release got %b want 0", att_if.att_ready); end
    idle(); tick(); #1;
    n_tests++; if (att_if.att_ready !== 1'b1) begin n_fail++; $display("FAIL lock_ready_idle got %b want 1", att_if.att_ready); end
    n_tests++; if (lock_count !== 8'd1 || match !== 1'b1) begin n_fail++; $display("FAIL lock_idle_state got cnt=%0d m=%b want 1/1", lock_count, match); end
  endtask

  task automatic test_valid_with_block();
    drive(1'b0, 1'b0, '0, 1'b1, 8'h5A, 1'b1);
    #1;
    n_tests++; if (att_if.att_ready !== 1'b0) begin n_fail++; $display("FAIL vb_ready got %b want 0", att_if.att_ready); end
    tick();
    n_tests++; if (att_if.res_valid !== 1'b0) begin n_fail++; $display("FAIL vb_res_valid got %b want 0", att_if.res_valid); end
    n_tests++; if (locked !== 1'b1 || lock_count !== 8'd2) begin n_fail++; $display("FAIL vb_locked got l=%b cnt=%0d want 1/2", locked, lock_count); end
    idle();
    for (int i = 0; i < LC; i++) begin
      tick();
      n_tests++; if (att_if.res_valid !== 1'b0) begin n_fail++; $display("FAIL vb_no_strobe_%0d got %b want 0", i, att_if.res_valid); end
    end
    tick(); #1;
    n_tests++; if (att_if.att_ready !== 1'b1) begin n_fail++; $display("FAIL vb_ready_after got %b want 1", att_if.att_ready); end
  endtask

  task automatic test_key_load_accept();
    drive(1'b0, 1'b1, 8'h33, 1'b1, 8'h33, 1'b0);
    tick();
    n_tests++; if (att_if.res_valid !== 1'b1 || att_if.res_ok !== 1'b1) begin n_fail++; $display("FAIL kl_accept got v=%b ok=%b want 1/1", att_if.res_valid, att_if.res_ok); end
    idle(); tick();
  endtask

  task automatic test_key_load_check();
    drive(1'b0, 1'b0, '0, 1'b1, 8'h44, 1'b0);
    tick();
    drive(1'b0, 1'b1, 8'h44, 1'b0, '0, 1'b0);
    n_tests++; if (att_if.res_valid !== 1'b1 || att_if.res_ok !== 1'b0) begin n_fail++; $display("FAIL kl_check_preload got v=%b ok=%b want 1/0", att_if.res_valid, att_if.res_ok); end
    tick();
    drive(1'b0, 1'b0, '0, 1'b1, 8'h44, 1'b0);
    tick();
    n_tests++; if (att_if.res_ok !== 1'b1) begin n_fail++; $display("FAIL kl_check_postload got %b want 1", att_if.res_ok); end
    idle(); tick();
    n_tests++; if (match !== 1'b1) begin n_fail++; $display("FAIL kl_check_match got %b want 1", match); end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b0, '0, 1'b1, 8'h00, 1'b0);
    tick(); idle(); tick();
    n_tests++; if (match !== 1'b0) begin n_fail++; $display("FAIL rm_pre_fail got %b want 0", match); end
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    tick(); idle(); tick();
    n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL rm_locked_c2 got %b want 1", locked); end
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    tick(); idle();
    n_tests++; if (locked !== 1'b0 || match !== 1'b1) begin n_fail++; $display("FAIL rm_state got l=%b m=%b want 0/1", locked, match); end
    n_tests++; if (lock_count !== 8'd0) begin n_fail++; $display("FAIL rm_lock_count got %0d want 0", lock_count); end
    #1;
    n_tests++; if (att_if.att_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready got %b want 1", att_if.att_ready); end
    // Reset on the acceptance cycle: the attempt must not produce a strobe.
    drive(1'b1, 1'b0, '0, 1'b1, 8'h00, 1'b0);
    tick(); idle();
    n_tests++; if (att_if.res_valid !== 1'b0 || att_if.res_ok !== 1'b0) begin n_fail++; $display("FAIL rm_accept_rst got v=%b ok=%b want 0/0", att_if.res_valid, att_if.res_ok); end
    tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      tick(); idle();
      repeat (LC + 1) tick();
      if (i == 254) begin
        n_tests++; if (lock_count !== 8'd255) begin n_fail++; $display("FAIL sat_255th got %0d want 255", lock_count); end
      end
    end
    n_tests++; if (lock_count !== 8'd255) begin n_fail++; $display("FAIL sat_256th got %0d want 255", lock_count); end
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL sat_unlocked got %b want 0", locked); end
  endtask

  // Reference model: cycles-remaining bookkeeping derived from the rules.
  task automatic test_random();
    logic [W-1:0] m_key, key_now, ki, ad;
    logic         m_check, m_release, m_res_ok, m_match, r, kl, av, blk, exp_rdy;
    int           m_lock_left, m_lock_count;
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    tick();
    m_key = '0; m_check = 1'b0; m_release = 1'b0; m_res_ok = 1'b0;
    m_match = 1'b1; m_lock_left = 0; m_lock_count = 0;
    for (int c = 0; c < 3000; c++) begin
      n_tests++; if (att_if.res_valid !== m_check) begin n_fail++; $display("FAIL rnd_res_valid c%0d got %b want %b", c, att_if.res_valid, m_check); end
      n_tests++; if (att_if.res_ok !== m_res_ok) begin n_fail++; $display("FAIL rnd_res_ok c%0d got %b want %b", c, att_if.res_ok, m_res_ok); end
      n_tests++; if (match !== m_match) begin n_fail++; $display("FAIL rnd_match c%0d got %b want %b", c, match, m_match); end
      n_tests++; if (locked !== (m_lock_left > 0)) begin n_fail++; $display("FAIL rnd_locked c%0d got %b want %b", c, locked, (m_lock_left > 0)); end
      n_tests++; if (lock_count !== 8'(m_lock_count)) begin n_fail++; $display("FAIL rnd_lock_count c%0d got %0d want %0d", c, lock_count, m_lock_count); end
      r   = ($urandom_range(0, 99) == 0);
      blk = ($urandom_range(0, 15) == 0);
      kl  = ($urandom_range(0, 7) == 0);
      ki  = ($urandom_range(0, 3) == 0) ? 8'h5A : W'($urandom);
      av  = 1'($urandom_range(0, 1));
      key_now = kl ? ki : m_key;
      ad  = ($urandom_range(0, 1) == 1) ? key_now : W'($urandom);
      drive(r, kl, ki, av, ad, blk);
      #1;
      exp_rdy = !m_check && (m_lock_left == 0) && !m_release && !blk;
      n_tests++; if (att_if.att_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready c%0d got %b want %b", c, att_if.att_ready, exp_rdy); end
      if (r) begin
        m_key = '0; m_check = 1'b0; m_release = 1'b0; m_res_ok = 1'b0;
        m_match = 1'b1; m_lock_left = 0; m_lock_count = 0;
      end else begin
        if (m_check) begin
          m_match = m_res_ok;
          m_check = 1'b0;
        end else if (m_lock_left > 0) begin
          m_lock_left--;
          if (m_lock_left == 0) begin m_release = 1'b1; m_match = 1'b1; end
        end else if (m_release) begin
          m_release = 1'b0;
        end else if (blk) begin
          m_lock_left = LC;
          if (m_lock_count < 255) m_lock_count++;
        end else if (av) begin
          m_check  = 1'b1;
          m_res_ok = (ad == key_now);
        end
        m_key = key_now;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_lockout();
    test_valid_with_block();
    test_key_load_accept();
    test_key_load_check();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/attempt_gate.md
ATTEMPT_GATE -- requirements
Module: attempt_gate

Interface
REQ-001 Parameter W, default 8, key and attempt width in bits.
REQ-002 Parameter LOCK_CYCLES, default 64, lockout duration in clk cycles (>=1).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 key_load  in  1  load key_in into key register this cycle.
REQ-006 key_in  in  W  reference key value.
REQ-007 att_valid  in  1  attempt offered.
REQ-008 att_data  in  W  attempt value.
REQ-009 att_ready  out  1  attempt can be accepted.
REQ-010 res_valid  out  1  one-cycle result strobe.
REQ-011 res_ok  out  1  result of last attempt; valid with res_valid, held afterwards.
REQ-012 match  out  1  level to the failure monitor; low while the latest result is a failure.
REQ-013 block  in  1  lockout request from the failure monitor.
REQ-014 locked  out  1  high while lockout is in progress.
REQ-015 lock_count  out  8  number of lockouts since reset, saturating.

Function
REQ-016 States: IDLE, CHECK, LOCKED, RELEASE.
REQ-017 att_ready SHALL be combinational: state==IDLE and block==0.
REQ-018 Attempt accepted on the cycle where att_valid and att_ready are both high; att_data registered; next state CHECK.
REQ-019 CHECK lasts exactly one cycle: res_valid=1, res_ok=(captured data==key), match<=res_ok, next state IDLE; latency from acceptance to res_valid is 1 cycle.
REQ-020 At most one attempt is accepted every 2 cycles; att_ready SHALL be low in CHECK.
REQ-021 match SHALL hold its value between results; a failure keeps it low until a success or a RELEASE.
REQ-022 In IDLE with block==1: no acceptance; next state LOCKED; lock_count increments on entry and saturates at 255.
REQ-023 block is ignored in CHECK, LOCKED and RELEASE; block in CHECK is acted on in the following IDLE cycle.
REQ-024 LOCKED: locked=1 for exactly LOCK_CYCLES cycles; att_ready=0; then RELEASE.
REQ-025 RELEASE lasts one cycle: match driven to 1, locked=0, next state IDLE; match remains 1 until the next failure.
REQ-026 key_load is honoured in every state; when it coincides with acceptance, the compare in CHECK uses the newly loaded key.
REQ-027 key_load during CHECK takes effect after the compare; the result uses the pre-load key.
REQ-028 res_valid is never high outside CHECK.

Reset
REQ-029 On rst: state=IDLE, key=0, res_valid=0, res_ok=0, match=1, locked=0, lock_count=0, lock timer=0.
REQ-030 rst overrides every other input in the same cycle, including mid-lockout and mid-CHECK; no result strobe is produced for an attempt interrupted by reset.

Structure
REQ-031 The state encoding and the default W/LOCK_CYCLES values SHALL reside in the shared package used by the wrapper.
REQ-032 Lockout timer SHALL be one sub-module, lock_timer (start, done, width from LOCK_CYCLES).
REQ-033 lock_count saturation SHALL be local to attempt_gate.

Verification
REQ-034 key_load key_in=0x5A; attempt 0x5A -> res_valid one cycle later, res_ok=1, match stays 1.
REQ-035 key=0x5A; attempt 0x11 -> res_ok=0, match=0 from the following cycle until the next success; attempt 0x5A later -> match=1.
REQ-036 Drive block=1 for one cycle in IDLE with LOCK_CYCLES=4 -> att_ready=0 the same cycle, locked=1 for 4 cycles, match=1 in RELEASE, lock_count=1.
REQ-037 att_valid=1 with block=1 in the same IDLE cycle -> no acceptance, no res_valid, LOCKED entered.
REQ-038 Assert key_load key_in=0x33 on the acceptance cycle of attempt 0x33 (old key 0x5A) -> res_ok=1; 256 lockouts -> lock_count stays 255.
REQ-039 Assert rst during LOCKED cycle 2 -> next cycle IDLE, locked=0, match=1, lock_count=0, att_ready=1.
